// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares one data-memory port between the CPU memory stage and the camera writer
// CPU has priority. The camera gets idle cycles, plus a forced burst after STARVE_MAX cycles of waiting.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BURST_LEN  = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              cam_valid,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_wdata,
  output logic              cam_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cam_owner
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {S_CPU, S_RD_WAIT, S_CAM} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic stall_c, we_c, grant_cam;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_CPU;
      starve_q <= '0;
      burst_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    rdata_d   = rdata_q;
    starve_d  = '0;
    stall_c   = 1'b0;
    we_c      = 1'b0;
    grant_cam = 1'b0;
    cpu_rdata = rdata_q;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;

    case (state_q)
      S_CPU: begin
        if (starve_q == SW'(STARVE_MAX)) begin
          // Starved camera pre-empts the CPU; this cycle counts as the first burst beat.
          grant_cam = cam_valid;
          stall_c   = cpu_req;
          burst_d   = BW'(1);
          if (BURST_LEN > 1) state_d = S_CAM;
        end else if (cpu_req) begin
          if (cpu_we) begin
            we_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = S_RD_WAIT;
          end
        end else begin
          grant_cam = cam_valid;
        end
      end
      S_RD_WAIT: begin
        cpu_rdata = mem_rdata;
        rdata_d   = mem_rdata;
        state_d   = S_CPU;
      end
      S_CAM: begin
        stall_c = cpu_req;
        if (cam_valid) begin
          grant_cam = 1'b1;
          burst_d   = burst_q + BW'(1);
          if (burst_q + BW'(1) == BW'(BURST_LEN)) state_d = S_CPU;
        end else begin
          state_d = S_CPU;
        end
      end
      default: state_d = S_CPU;
    endcase

    if (grant_cam) begin
      mem_addr  = cam_addr;
      mem_wdata = cam_wdata;
      we_c      = 1'b1;
    end

    if (cam_valid && !grant_cam)
      starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
  end

  // Handshake outputs are held low for the whole reset assertion, not just after the next edge.
  assign cpu_stall = reset & stall_c;
  assign cam_ready = reset & grant_cam;
  assign mem_we    = reset & we_c;
  assign cam_owner = reset & (state_q == S_CAM);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - randomized self-checking bench for dmem_port_arbiter
// A transaction-level model of the port decides who owns each cycle and tracks RAM contents.
module tb_dmem_port_arbiter;

  localparam int STARVE_MAX = 8;
  localparam int BURST_LEN  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cam_valid;
  logic [31:0] cpu_addr, cpu_wdata, cam_addr, cam_wdata;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, cam_ready, mem_we, cam_owner;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .BURST_LEN(BURST_LEN), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cam_valid(cam_valid), .cam_addr(cam_addr), .cam_wdata(cam_wdata), .cam_ready(cam_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .cam_owner(cam_owner)
  );

  // Synchronous-read RAM, 64 words, word index from address bits [7:2].
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:2]];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state: cycles the camera has waited, forced-burst beats still owed, pending load.
  int          m_wait = 0;
  int          m_left = 0;
  bit          m_load = 0;
  logic [5:0]  m_lidx;
  logic [31:0] m_rdata = '0;
  logic [31:0] ref_mem [64];

  logic        o_stall, o_ready, o_we, o_owner;
  logic [31:0] o_addr, o_rdata;

  task automatic step();
    logic e_stall, e_ready, e_we, e_owner, e_load;
    logic [31:0] e_addr, e_wdata, e_rdata;
    #2;
    o_stall = cpu_stall; o_ready = cam_ready; o_we = mem_we; o_owner = cam_owner;
    o_addr  = mem_addr;  o_rdata = cpu_rdata;
    e_stall = 0; e_ready = 0; e_we = 0; e_owner = 0; e_load = 0;
    e_addr = 'x; e_wdata = 'x; e_rdata = m_rdata;
    if (!reset) begin
      m_wait = 0; m_left = 0; m_load = 0; m_rdata = '0; e_rdata = '0;
    end else begin
      if (m_load) begin
        e_rdata = ref_mem[m_lidx];
        m_rdata = e_rdata;
        m_load  = 0;
      end else if (m_left > 0) begin
        e_owner = 1;
        e_stall = cpu_req;
        if (cam_valid) begin e_ready = 1; m_left--; end
        else m_left = 0;
      end else if (m_wait == STARVE_MAX) begin
        e_stall = cpu_req;
        e_ready = cam_valid;
        m_left  = BURST_LEN - 1;
      end else if (cpu_req && cpu_we) begin
        e_we = 1; e_addr = cpu_addr; e_wdata = cpu_wdata;
      end else if (cpu_req) begin
        e_stall = 1; e_load = 1; e_addr = cpu_addr;
        m_load = 1; m_lidx = cpu_addr[7:2];
      end else if (cam_valid) begin
        e_ready = 1;
      end
      if (e_ready) begin e_we = 1; e_addr = cam_addr; e_wdata = cam_wdata; end
      if (e_we) ref_mem[e_addr[7:2]] = e_wdata;
      if (cam_valid && !e_ready) m_wait = (m_wait < STARVE_MAX) ? m_wait + 1 : STARVE_MAX;
      else m_wait = 0;
    end
    chk("cpu_stall", o_stall, e_stall);
    chk("cam_ready", o_ready, e_ready);
    chk("mem_we", o_we, e_we);
    chk("cam_owner", o_owner, e_owner);
    chk("cpu_rdata", o_rdata, e_rdata);
    if (e_we) begin
      chk("wr_addr", o_addr, e_addr);
      chk("wr_data", mem_wdata, e_wdata);
    end
    if (e_load) chk("rd_addr", o_addr, e_addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic new_cam_beat();
    cam_addr  = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
    cam_wdata = $urandom;
  endtask

  task automatic store_cam_cycle();
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 32'($urandom_range(0, 63)) << 2; cpu_wdata = $urandom;
    cam_valid = 1;
    step();
    if (o_ready) new_cam_beat();
  endtask

  initial begin
    reset = 0; cpu_req = 1; cpu_we = 0; cam_valid = 1;
    cpu_addr = 32'h40; cpu_wdata = '0; cam_addr = 32'h1000; cam_wdata = '0;
    @(negedge clk);
    step();
    chk("rst_mem_we", o_we, 0);
    chk("rst_cam_ready", o_ready, 0);
    chk("rst_cpu_stall", o_stall, 0);
    reset = 1; cam_valid = 0; cpu_req = 0;

    for (int i = 0; i < 64; i++) begin
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'(i) << 2; cpu_wdata = $urandom;
      step();
    end

    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF;
    step();
    chk("t2_we", o_we, 1);
    chk("t2_addr", o_addr, 32'h40);
    chk("t2_stall", o_stall, 0);

    cpu_we = 0; cpu_wdata = '0;
    step();
    chk("t3_issue_stall", o_stall, 1);
    chk("t3_issue_addr", o_addr, 32'h40);
    step();
    chk("t3_wait_stall", o_stall, 0);
    chk("t3_wait_rdata", o_rdata, 32'hDEADBEEF);
    cpu_req = 0;
    step();
    chk("t3_hold_rdata", o_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 6; i++) begin
      cam_valid = 1; cam_addr = 32'h1000 + 32'(i * 4); cam_wdata = $urandom;
      step();
      chk("t4_ready", o_ready, 1);
      chk("t4_addr", o_addr, 32'h1000 + 32'(i * 4));
    end

    new_cam_beat();
    for (int i = 0; i < 24; i++) begin
      store_cam_cycle();
      chk("t5_pattern_ready", o_ready, (i % 12) >= 8);
      chk("t5_pattern_stall", o_stall, (i % 12) >= 8);
    end

    for (int i = 0; i < 10; i++) store_cam_cycle();
    chk("t6_second_beat_owner", o_owner, 1);
    cam_valid = 0;
    step();
    chk("t6_drop_ready", o_ready, 0);
    step();
    chk("t6_exit_owner", o_owner, 0);

    for (int i = 0; i < 10; i++) store_cam_cycle();
    reset = 0;
    step();
    chk("t6_rst_ready", o_ready, 0);
    chk("t6_rst_stall", o_stall, 0);
    reset = 1;
    for (int i = 0; i < 9; i++) begin
      store_cam_cycle();
      if (i == 7) chk("t6_restart_wait", o_ready, 0);
      if (i == 8) chk("t6_restart_force", o_ready, 1);
    end

    cam_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      bit can_change;
      can_change = !cam_valid || o_ready;
      reset     = ($urandom_range(0, 199) != 0);
      cpu_req   = ($urandom_range(0, 99) < 60);
      cpu_we    = $urandom_range(0, 1);
      cpu_addr  = 32'($urandom_range(0, 63)) << 2;
      cpu_wdata = $urandom;
      if (can_change) begin
        cam_valid = ($urandom_range(0, 99) < 55);
        new_cam_beat();
      end else if ($urandom_range(0, 9) == 0) begin
        cam_valid = 0;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
